branch_scorer: RTL and testbench

BRANCH_SCORER -- requirements
Module: branch_scorer

---
 rtl/branch_pkg.sv | 13 +
 rtl/branch_scorer_if.sv | 29 ++
 rtl/outcome_fifo.sv | 51 +++++
 rtl/branch_scorer.sv | 107 ++++++++++
 tb/tb_branch_scorer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared scorer FSM state type and default sizing
package branch_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

endpackage

// File: rtl/branch_scorer_if.sv
// rtl/branch_scorer_if.sv - outcome stream and predictor update handshake
interface branch_scorer_if;

    logic br_valid;
    logic br_taken;
    logic br_ready;
    logic pred_request;
    logic pred_taken;
    logic pred_prediction;

    modport master (
        output br_valid,
        output br_taken,
        output pred_prediction,
        input  br_ready,
        input  pred_request,
        input  pred_taken
    );

    modport slave (
        input  br_valid,
        input  br_taken,
        input  pred_prediction,
        output br_ready,
        output pred_request,
        output pred_taken
    );

endinterface

// File: rtl/outcome_fifo.sv
// rtl/outcome_fifo.sv - in-order 1-bit outcome queue with wrap-bit pointers
module outcome_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] mem;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read once its write pointer has passed it.
    always_ff @(posedge clk) begin
        if (push && !full && !clear)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/branch_scorer.sv
// rtl/branch_scorer.sv - scores resolved branches against a 2-bit predictor
module branch_scorer
    import branch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    branch_scorer_if.slave     bif,
    output logic [CNT_W-1:0]   total_cnt,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    logic        ready_en;
    logic        pred_reg;
    logic        req_q;
    logic        full;
    logic        empty;
    logic        head;
    logic [AW:0] count;
    logic        push_fire;
    logic        pop_fire;
    logic        more_after_pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // ready_en keeps br_ready low through reset and for the first cycle after release.
    assign bif.br_ready    = ready_en && !full;
    assign push_fire       = bif.br_valid && bif.br_ready && !clear;
    assign pop_fire        = (state == UPDATE) && !clear;
    assign more_after_pop  = (count > (AW+1)'(1)) || push_fire;
    assign busy            = !empty || (state != IDLE);
    assign bif.pred_request = req_q;
    assign bif.pred_taken  = (state != IDLE) && head;

    outcome_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push_fire),
        .din   (bif.br_taken),
        .pop   (pop_fire),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            pred_reg  <= 1'b0;
            req_q     <= 1'b0;
            total_cnt <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (clear) begin
                state     <= IDLE;
                pred_reg  <= 1'b0;
                req_q     <= 1'b0;
                total_cnt <= '0;
                hit_cnt   <= '0;
                miss_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        req_q <= 1'b0;
                        if (!empty)
                            state <= LOOKUP;
                    end
                    LOOKUP: begin
                        pred_reg <= bif.pred_prediction;
                        req_q    <= 1'b1;
                        state    <= UPDATE;
                    end
                    UPDATE: begin
                        req_q     <= 1'b0;
                        total_cnt <= sat_inc(total_cnt);
                        if (pred_reg == head)
                            hit_cnt <= sat_inc(hit_cnt);
                        else
                            miss_cnt <= sat_inc(miss_cnt);
                        state <= more_after_pop ? LOOKUP : IDLE;
                    end
                    default: begin
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_scorer.sv
// tb/tb_branch_scorer.sv - scoreboard bench for branch_scorer
module tb_branch_scorer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic clear2 = 1'b0;

    always #5 clk = ~clk;

    branch_scorer_if bif ();
    branch_scorer_if bif2 ();

    logic [15:0] total_cnt, hit_cnt, miss_cnt;
    logic        busy;
    logic [3:0]  total2, hit2, miss2;
    logic        busy2;

    branch_scorer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bif(bif),
        .total_cnt(total_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .busy(busy)
    );

    branch_scorer #(.DEPTH(4), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .bif(bif2),
        .total_cnt(total2), .hit_cnt(hit2), .miss_cnt(miss2), .busy(busy2)
    );

    // 2-bit saturating predictor, weakly-not-taken after pred_init
    logic [1:0] pctr = 2'b01;
    logic       pred_init = 1'b0;
    always @(posedge clk) begin
        if (pred_init)
            pctr <= 2'b01;
        else if (bif.pred_request)
            pctr <= bif.pred_taken ? ((pctr == 2'b11) ? pctr : pctr + 2'b01)
                                   : ((pctr == 2'b00) ? pctr : pctr - 2'b01);
    end
    assign bif.pred_prediction  = pctr[1];
    assign bif2.pred_prediction = 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    int   pulse_cyc[$];
    int   pulse_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bif.pred_request) begin : mon
            logic e;
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pred_request: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pred_taken", bif.pred_taken, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, output int at);
        int n;
        n = 0;
        bif.br_valid = 1'b1;
        bif.br_taken = t;
        @(negedge clk);
        while (!bif.br_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        if (!bif.br_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got br_ready=0 expected 1");
        end else begin
            exp_q.push_back(t);
        end
        @(posedge clk);
        #1;
        bif.br_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", int'(!busy && exp_q.size() == 0), 1);
        tick();
    endtask

    task automatic wait_pulse();
        int n;
        n = 0;
        @(negedge clk);
        while (!bif.pred_request && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_seen", bif.pred_request, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        pred_init = 1'b1;
        tick();
        clear = 1'b0;
        pred_init = 1'b0;
        exp_q.delete();
        pulse_cyc.delete();
    endtask

    initial begin
        int at, first_at, accepted, first_stall, n, p0;
        bif.br_valid = 1'b0;
        bif.br_taken = 1'b0;
        bif2.br_valid = 1'b0;
        bif2.br_taken = 1'b0;

        // reset state and first-cycle ready
        tick();
        chk("rst_br_ready", bif.br_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pred_request", bif.pred_request, 0);
        chk("rst_pred_taken", bif.pred_taken, 0);
        chk("rst_total", total_cnt, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", bif.br_ready, 0);
        @(negedge clk);
        chk("ready_after_release", bif.br_ready, 1);
        tick();

        // T,T,T against weakly-not-taken predictor
        pred_init = 1'b1;
        tick();
        pred_init = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1, at);
        wait_idle();
        chk("ttt_total", total_cnt, 3);
        chk("ttt_hit", hit_cnt, 2);
        chk("ttt_miss", miss_cnt, 1);

        // N x4 back-to-back: latency and throughput
        do_clear();
        chk("clear_total", total_cnt, 0);
        push(1'b0, first_at);
        for (int i = 0; i < 3; i++) push(1'b0, at);
        wait_idle();
        chk("nnnn_pulses", pulse_cyc.size(), 4);
        if (pulse_cyc.size() == 4) begin
            chk("nnnn_latency", pulse_cyc[0] - first_at, 3);
            for (int i = 1; i < 4; i++)
                chk("nnnn_interval", pulse_cyc[i] - pulse_cyc[i-1], 2);
        end
        chk("nnnn_hit", hit_cnt, 4);
        chk("nnnn_miss", miss_cnt, 0);

        // continuous offer: FIFO fills after 5 accepts (pop at 3rd cycle)
        do_clear();
        accepted = 0;
        first_stall = -1;
        n = 0;
        bif.br_valid = 1'b1;
        bif.br_taken = 1'b0;
        while (accepted < 8 && n < 100) begin
            @(negedge clk);
            if (bif.br_ready) begin
                accepted++;
                exp_q.push_back(1'b0);
            end else if (first_stall < 0) begin
                first_stall = accepted;
            end
            tick();
            n++;
        end
        bif.br_valid = 1'b0;
        chk("burst_accepted", accepted, 8);
        chk("burst_first_stall", first_stall, 5);
        wait_idle();
        chk("burst_total", total_cnt, 8);

        // push coinciding with last pop: UPDATE -> LOOKUP with no IDLE bubble
        do_clear();
        push(1'b1, at);
        wait_pulse();
        chk("same_cycle_ready", bif.br_ready, 1);
        bif.br_valid = 1'b1;
        bif.br_taken = 1'b1;
        exp_q.push_back(1'b1);
        tick();
        bif.br_valid = 1'b0;
        @(negedge clk);
        chk("nobubble_lookup_req", bif.pred_request, 0);
        chk("nobubble_busy", busy, 1);
        @(negedge clk);
        chk("nobubble_update_req", bif.pred_request, 1);
        wait_idle();
        chk("nobubble_total", total_cnt, 2);

        // clear during UPDATE with 2 entries queued
        push(1'b1, at);
        push(1'b0, at);
        wait_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        chk("clr_upd_total", total_cnt, 0);
        chk("clr_upd_hit", hit_cnt, 0);
        chk("clr_upd_miss", miss_cnt, 0);
        chk("clr_upd_busy", busy, 0);
        p0 = pulse_cnt;
        repeat (10) @(negedge clk);
        chk("clr_upd_no_pulse", pulse_cnt - p0, 0);
        tick();

        // async reset while in LOOKUP with 3 entries queued
        for (int i = 0; i < 4; i++) push(1'b1, at);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_br_ready", bif.br_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pred_request", bif.pred_request, 0);
        chk("arst_pred_taken", bif.pred_taken, 0);
        chk("arst_total", total_cnt, 0);
        exp_q.delete();
        p0 = pulse_cnt;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_pulse", pulse_cnt - p0, 0);
        tick();
        push(1'b0, at);
        wait_idle();
        chk("arst_new_total", total_cnt, 1);

        // CNT_W=4 saturation: 20 taken, prediction tied taken
        accepted = 0;
        n = 0;
        bif2.br_valid = 1'b1;
        bif2.br_taken = 1'b1;
        while (accepted < 20 && n < 200) begin
            @(negedge clk);
            if (bif2.br_ready) accepted++;
            tick();
            n++;
        end
        bif2.br_valid = 1'b0;
        chk("sat_accepted", accepted, 20);
        n = 0;
        @(negedge clk);
        while (busy2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sat_idle", busy2, 0);
        chk("sat_total", total2, 15);
        chk("sat_hit", hit2, 15);
        chk("sat_miss", miss2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
